fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of instr_mem.
- Holds the program counter and drives the word address into instr_mem.
- Captures the combinationally returned instruction into an IF/ID output register.
- Handles stall, branch/jump redirect with wrong-path flush, and fault detection for misaligned or out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, IF/ID register, redirect/flush, fetch faults
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   stall              hold PC and IF/ID register
//   redirect_valid     taken branch/jump this cycle; redirect_target is its byte address
//   imem_addr          word address into instr_mem (combinational from pc)
//   imem_instr         instruction returned by instr_mem in the same cycle
//   if_valid, if_pc, if_pc_plus4, if_instr   IF/ID register
//   fault, fault_pc    sticky fetch fault and the offending byte address
//   fetch_count        instructions delivered, wraps modulo 2^32
module fetch_unit #(
  parameter int              ADDR_WIDTH = 9,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]       imem_instr,
  output logic                  if_valid,
  output logic [XLEN-1:0]       if_pc,
  output logic [XLEN-1:0]       if_pc_plus4,
  output logic [XLEN-1:0]       if_instr,
  output logic                  fault,
  output logic [XLEN-1:0]       fault_pc,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;

  // One extra bit so that pc+4 wrapping past 2^XLEN is seen as illegal.
  logic [XLEN:0]   pc_inc;
  logic            pc_inc_legal;
  logic            target_legal;
  logic            reset_pc_legal;

  function automatic logic is_legal(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00) && (a[XLEN-1:ADDR_WIDTH+2] == '0);
  endfunction

  assign imem_addr      = pc[ADDR_WIDTH+1:2];
  assign pc_inc         = {1'b0, pc} + (XLEN+1)'(4);
  assign pc_inc_legal   = !pc_inc[XLEN] && is_legal(pc_inc[XLEN-1:0]);
  assign target_legal   = is_legal(redirect_target);
  assign reset_pc_legal = is_legal(RESET_PC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          // Single settling edge: pc already holds RESET_PC, nothing captured yet.
          if (reset_pc_legal) begin
            state <= RUN;
          end else begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= RESET_PC;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            // Whatever imem returns this cycle is wrong-path; drop it.
            if_valid <= 1'b0;
            if (target_legal) begin
              pc <= redirect_target;
            end else begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= redirect_target;
            end
          end else if (!stall) begin
            if_instr    <= imem_instr;
            if_pc       <= pc;
            if_pc_plus4 <= pc_inc[XLEN-1:0];
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            // The last word is still delivered; pc stays on it rather than wrapping.
            if (pc_inc_legal) begin
              pc <= pc_inc[XLEN-1:0];
            end else begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= pc_inc[XLEN-1:0];
            end
          end
        end

        FAULT: begin
          if_valid <= 1'b0;
          fault    <= 1'b1;
        end

        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule
